// File: rtl/uart_lite.sv
// uart_lite: 8250-style serial port with toggle request/acknowledge host handshake,
// fixed 8N1 framing, 16x-oversampled receiver feeding a small RX FIFO, and a THR
// holding register in front of the transmit shifter.
module uart_lite #(
  parameter int unsigned BASE_DIV  = 27,
  parameter int unsigned RX_DEPTH  = 16,
  parameter int unsigned DIV_RESET = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       cpu_iordin,
  output logic       cpu_iordout,
  input  logic       cpu_iowrin,
  output logic       cpu_iowrout,
  output logic       ready,
  output logic       irq,
  input  logic       rxd,
  output logic       txd
);

  localparam int unsigned PtrW = $clog2(RX_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  // Host interface and register file
  logic [7:0]  dout_q, dout_d;
  logic        rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d;
  logic [7:0]  dll_q, dll_d, dlm_q, dlm_d, lcr_q, lcr_d;
  logic [1:0]  ier_q, ier_d;
  // Baud generator
  logic [15:0] pre_cnt_q, pre_cnt_d, div_cnt_q, div_cnt_d;
  // Receiver
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [3:0]  rx_tick_q, rx_tick_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  fifo_q [RX_DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic        oe_q, oe_d, fe_q, fe_d;
  // Transmitter
  logic [7:0]  thr_q, thr_d;
  logic        thr_full_q, thr_full_d;
  tx_state_e   tx_state_q, tx_state_d;
  logic [3:0]  tx_tick_q, tx_tick_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;
  logic        thre_prev_q, thre_pend_q, thre_pend_d;

  logic        do_wr, do_rd, dlab;
  logic        wr_thr, wr_dll, wr_dlm, wr_ier, wr_lcr, rd_rbr, rd_iir, rd_lsr;
  logic        tick, pre_wrap;
  logic [15:0] div_eff;
  logic        push, stop_err, push_ok, pop, dr, full;
  logic        thre, temt;
  logic [7:0]  iir, lsr, rd_data;

  // Access decode; a pending write always wins over a pending read
  always_comb begin
    do_wr  = cpu_iowrin != wr_ack_q;
    do_rd  = (cpu_iordin != rd_ack_q) && !do_wr;
    dlab   = lcr_q[7];
    wr_thr = do_wr && (addr == 3'd0) && !dlab;
    wr_dll = do_wr && (addr == 3'd0) && dlab;
    wr_ier = do_wr && (addr == 3'd1) && !dlab;
    wr_dlm = do_wr && (addr == 3'd1) && dlab;
    wr_lcr = do_wr && (addr == 3'd3);
    rd_rbr = do_rd && (addr == 3'd0) && !dlab;
    rd_iir = do_rd && (addr == 3'd2);
    rd_lsr = do_rd && (addr == 3'd5);
  end

  // Status words and read data mux
  always_comb begin
    dr   = count_q != '0;
    full = count_q == CntW'(RX_DEPTH);
    thre = !thr_full_q;
    temt = thre && (tx_state_q == TxIdle);
    lsr  = {1'b0, temt, thre, 1'b0, fe_q, 1'b0, oe_q, dr};
    if (ier_q[0] && dr) begin
      iir = 8'h04;
    end else if (ier_q[1] && thre_pend_q) begin
      iir = 8'h02;
    end else begin
      iir = 8'h01;
    end
    rd_data = 8'h00;
    case (addr)
      3'd0:    rd_data = dlab ? dll_q : (dr ? fifo_q[rptr_q] : 8'h00);
      3'd1:    rd_data = dlab ? dlm_q : {6'b0, ier_q};
      3'd2:    rd_data = iir;
      3'd3:    rd_data = lcr_q;
      3'd5:    rd_data = lsr;
      default: rd_data = 8'h00;
    endcase
  end

  // Register writes, acknowledges, read data capture and THRE interrupt latch
  always_comb begin
    dll_d       = wr_dll ? din : dll_q;
    dlm_d       = wr_dlm ? din : dlm_q;
    lcr_d       = wr_lcr ? din : lcr_q;
    ier_d       = wr_ier ? din[1:0] : ier_q;
    wr_ack_d    = do_wr ? cpu_iowrin : wr_ack_q;
    rd_ack_d    = do_rd ? cpu_iordin : rd_ack_q;
    dout_d      = do_rd ? rd_data : dout_q;
    thre_pend_d = thre_pend_q;
    if ((thre && !thre_prev_q) || (wr_ier && din[1] && !ier_q[1] && thre)) begin
      thre_pend_d = 1'b1;
    end
    if (wr_thr || (rd_iir && (iir == 8'h02))) begin
      thre_pend_d = 1'b0;
    end
  end

  // Baud generator: BASE_DIV prescaler then divisor counter gives the 16x tick
  always_comb begin
    div_eff  = ({dlm_q, dll_q} == 16'd0) ? 16'd1 : {dlm_q, dll_q};
    pre_wrap = pre_cnt_q == 16'(BASE_DIV - 1);
    tick     = pre_wrap && (div_cnt_q == div_eff - 16'd1);
    if (wr_dll || wr_dlm) begin
      pre_cnt_d = 16'd0;
      div_cnt_d = 16'd0;
    end else begin
      pre_cnt_d = pre_wrap ? 16'd0 : pre_cnt_q + 16'd1;
      div_cnt_d = div_cnt_q;
      if (pre_wrap) begin
        div_cnt_d = (div_cnt_q == div_eff - 16'd1) ? 16'd0 : div_cnt_q + 16'd1;
      end
    end
  end

  // Receive FSM: start validated mid-bit, data and stop sampled every 16 ticks after
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    push       = 1'b0;
    stop_err   = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RxStart;
          rx_tick_d  = 4'd0;
        end
      end
      RxStart: begin
        if (tick) begin
          rx_tick_d = rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd7) begin
            rx_tick_d  = 4'd0;
            rx_bit_d   = 3'd0;
            rx_state_d = rx_s2_q ? RxIdle : RxData;
          end
        end
      end
      RxData: begin
        if (tick) begin
          rx_tick_d = rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd15) begin
            rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) begin
              rx_state_d = RxStop;
            end
          end
        end
      end
      RxStop: begin
        if (tick) begin
          rx_tick_d = rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd15) begin
            push       = 1'b1;
            stop_err   = !rx_s2_q;
            rx_state_d = RxIdle;
          end
        end
      end
    endcase
  end

  // RX FIFO pointers and sticky error flags; an LSR read clears errors unless one recurs
  always_comb begin
    push_ok = push && !full;
    pop     = rd_rbr && dr;
    wptr_d  = push_ok ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PtrW'(1) : rptr_q;
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CntW'(1);
    end
    oe_d = rd_lsr ? 1'b0 : oe_q;
    fe_d = rd_lsr ? 1'b0 : fe_q;
    if (push && full) begin
      oe_d = 1'b1;
    end
    if (push && stop_err) begin
      fe_d = 1'b1;
    end
  end

  // Transmit FSM; the holding register reloads at stop end so frames run back to back
  always_comb begin
    logic load;
    load       = 1'b0;
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    thr_d      = thr_q;
    thr_full_d = thr_full_q;
    unique case (tx_state_q)
      TxIdle: load = thr_full_q;
      TxStart: begin
        if (tick) begin
          tx_tick_d = tx_tick_q + 4'd1;
          if (tx_tick_q == 4'd15) begin
            tx_state_d = TxData;
            tx_bit_d   = 3'd0;
          end
        end
      end
      TxData: begin
        if (tick) begin
          tx_tick_d = tx_tick_q + 4'd1;
          if (tx_tick_q == 4'd15) begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) begin
              tx_state_d = TxStop;
            end
          end
        end
      end
      TxStop: begin
        if (tick) begin
          tx_tick_d = tx_tick_q + 4'd1;
          if (tx_tick_q == 4'd15) begin
            if (thr_full_q) begin
              load = 1'b1;
            end else begin
              tx_state_d = TxIdle;
            end
          end
        end
      end
    endcase
    if (load) begin
      tx_shift_d = thr_q;
      tx_state_d = TxStart;
      tx_tick_d  = 4'd0;
      thr_full_d = 1'b0;
    end
    // A write in the load cycle lands in the now-empty holding register
    if (wr_thr) begin
      thr_d      = din;
      thr_full_d = 1'b1;
    end
    unique case (tx_state_d)
      TxStart: txd_d = 1'b0;
      TxData:  txd_d = tx_shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q      <= 8'h00;
      rd_ack_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
      dll_q       <= 8'(DIV_RESET);
      dlm_q       <= 8'(DIV_RESET >> 8);
      lcr_q       <= 8'h03;
      ier_q       <= 2'b00;
      pre_cnt_q   <= 16'd0;
      div_cnt_q   <= 16'd0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RxIdle;
      rx_tick_q   <= 4'd0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'h00;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      oe_q        <= 1'b0;
      fe_q        <= 1'b0;
      thr_q       <= 8'h00;
      thr_full_q  <= 1'b0;
      tx_state_q  <= TxIdle;
      tx_tick_q   <= 4'd0;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'h00;
      txd_q       <= 1'b1;
      thre_prev_q <= 1'b1;
      thre_pend_q <= 1'b0;
    end else begin
      dout_q      <= dout_d;
      rd_ack_q    <= rd_ack_d;
      wr_ack_q    <= wr_ack_d;
      dll_q       <= dll_d;
      dlm_q       <= dlm_d;
      lcr_q       <= lcr_d;
      ier_q       <= ier_d;
      pre_cnt_q   <= pre_cnt_d;
      div_cnt_q   <= div_cnt_d;
      rx_s1_q     <= rxd;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      rx_state_q  <= rx_state_d;
      rx_tick_q   <= rx_tick_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      oe_q        <= oe_d;
      fe_q        <= fe_d;
      thr_q       <= thr_d;
      thr_full_q  <= thr_full_d;
      tx_state_q  <= tx_state_d;
      tx_tick_q   <= tx_tick_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      txd_q       <= txd_d;
      thre_prev_q <= thre;
      thre_pend_q <= thre_pend_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_q[wptr_q] <= rx_shift_q;
    end
  end

  assign dout        = dout_q;
  assign cpu_iordout = rd_ack_q;
  assign cpu_iowrout = wr_ack_q;
  assign ready       = (cpu_iordin == rd_ack_q) && (cpu_iowrin == wr_ack_q);
  assign irq         = (ier_q[0] && dr) || (ier_q[1] && thre_pend_q);
  assign txd         = txd_q;

endmodule
